// File: rtl/bram_bist_pkg.sv
// rtl/bram_bist_pkg.sv - shared types and pattern constants for the BRAM self-test sequencer
package bram_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_W0,
        ST_R0,
        ST_W1,
        ST_R1,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        MODE_ADDR    = 2'd0,
        MODE_CHECKER = 2'd1,
        MODE_ONES    = 2'd2,
        MODE_XOR     = 2'd3
    } mode_e;

    // Repeating units; the pattern generator replicates and truncates them to the word width.
    localparam logic [1:0]  CHECKER_UNIT = 2'b10;
    localparam logic [15:0] XOR_UNIT     = 16'hA5A5;

    function automatic int unit_reps(input int width, input int unit_w);
        return (width + unit_w - 1) / unit_w;
    endfunction

endpackage

// File: rtl/bram_bist_if.sv
// rtl/bram_bist_if.sv - true dual-port BRAM port bundle driven by the self-test sequencer
interface bram_bist_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10
);
    logic [DATA_WIDTH-1:0] data_a;
    logic [DATA_WIDTH-1:0] data_b;
    logic [ADDR_WIDTH-1:0] addr_a;
    logic [ADDR_WIDTH-1:0] addr_b;
    logic                  we_a;
    logic                  we_b;
    logic [DATA_WIDTH-1:0] q_a;
    logic [DATA_WIDTH-1:0] q_b;

    modport master (
        output data_a, data_b, addr_a, addr_b, we_a, we_b,
        input  q_a, q_b
    );

    modport slave (
        input  data_a, data_b, addr_a, addr_b, we_a, we_b,
        output q_a, q_b
    );
endinterface

// File: rtl/bram_bist_pattern.sv
// rtl/bram_bist_pattern.sv - combinational test pattern P(addr, mode), optionally inverted
module bram_bist_pattern
    import bram_bist_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [1:0]            mode,
    input  logic                  invert,
    output logic [DATA_WIDTH-1:0] pattern
);
    localparam int CHK_REPS = unit_reps(DATA_WIDTH, 2);
    localparam int XOR_REPS = unit_reps(DATA_WIDTH, 16);
    localparam logic [2*CHK_REPS-1:0]  CHK_FULL = {CHK_REPS{CHECKER_UNIT}};
    localparam logic [16*XOR_REPS-1:0] XOR_FULL = {XOR_REPS{XOR_UNIT}};
    localparam logic [DATA_WIDTH-1:0]  CHK_SEED = CHK_FULL[DATA_WIDTH-1:0];
    localparam logic [DATA_WIDTH-1:0]  XOR_SEED = XOR_FULL[DATA_WIDTH-1:0];

    logic [DATA_WIDTH-1:0] addr_ext;
    logic [DATA_WIDTH-1:0] base;

    always_comb begin
        addr_ext = DATA_WIDTH'(addr);
        base     = '0;
        case (mode_e'(mode))
            MODE_ADDR:    base = addr_ext;
            MODE_CHECKER: base = addr[0] ? ~CHK_SEED : CHK_SEED;
            MODE_ONES:    base = '1;
            MODE_XOR:     base = addr_ext ^ XOR_SEED;
            default:      base = '0;
        endcase
        pattern = invert ? ~base : base;
    end
endmodule

// File: rtl/bram_bist.sv
// rtl/bram_bist.sv - four-phase march sequencer over both BRAM ports with latency-matched compare
module bram_bist
    import bram_bist_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10,
    parameter int RD_LATENCY = 1,
    parameter int ERR_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [1:0]            mode,
    bram_bist_if.master           ram,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ERR_WIDTH-1:0]  err_count,
    output logic [ADDR_WIDTH-1:0] err_addr
);
    localparam int              K_W      = (ADDR_WIDTH > 1) ? ADDR_WIDTH - 1 : 1;
    localparam logic [K_W-1:0]  K_LAST   = K_W'((2 ** (ADDR_WIDTH - 1)) - 1);
    localparam logic [1:0]      DRN_LAST = 2'(RD_LATENCY);
    localparam int              L        = RD_LATENCY;

    state_e                state_q, state_d;
    logic [K_W-1:0]        k_q, k_d;
    logic [1:0]            drn_q, drn_d;
    logic [1:0]            mode_q, mode_d;
    logic                  go;

    logic [ADDR_WIDTH-1:0] addr_a_q, addr_a_d, addr_b_q, addr_b_d;
    logic [DATA_WIDTH-1:0] data_a_q, data_a_d, data_b_q, data_b_d;
    logic [DATA_WIDTH-1:0] exp_a_q, exp_a_d, exp_b_q, exp_b_d;
    logic                  we_q, we_d, rd_q, rd_d, inv_d;
    logic                  busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic [ERR_WIDTH-1:0]  err_q, err_d;
    logic [ADDR_WIDTH-1:0] eaddr_q, eaddr_d;
    logic [DATA_WIDTH-1:0] pat_a, pat_b;

    logic [L-1:0]                 pv_a_q, pv_a_d, pv_b_q, pv_b_d;
    logic [L-1:0][DATA_WIDTH-1:0] pe_a_q, pe_a_d, pe_b_q, pe_b_d;
    logic [L-1:0][ADDR_WIDTH-1:0] pad_a_q, pad_a_d, pad_b_q, pad_b_d;
    logic                         mis_a, mis_b;
    logic [ERR_WIDTH:0]           err_sum;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        drn_d   = drn_q;
        mode_d  = mode_q;
        go      = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    go      = 1'b1;
                    state_d = ST_W0;
                    k_d     = '0;
                    drn_d   = '0;
                    mode_d  = mode;
                end
            end
            ST_W0, ST_W1: begin
                if (k_q == K_LAST) begin
                    state_d = (state_q == ST_W0) ? ST_R0 : ST_R1;
                    k_d     = '0;
                end else begin
                    k_d = k_q + K_W'(1);
                end
            end
            ST_R0, ST_R1: begin
                // Drain cycles keep the last addresses on the ports while reads retire.
                if (drn_q == 2'd0) begin
                    if (k_q == K_LAST) drn_d = 2'd1;
                    else               k_d   = k_q + K_W'(1);
                end else if (drn_q == DRN_LAST) begin
                    drn_d   = '0;
                    k_d     = '0;
                    state_d = (state_q == ST_R0) ? ST_W1 : ST_DONE;
                end else begin
                    drn_d = drn_q + 2'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_d   = (state_d == ST_W0) || (state_d == ST_R0) || (state_d == ST_W1) || (state_d == ST_R1);
        we_d     = (state_d == ST_W0) || (state_d == ST_W1);
        rd_d     = ((state_d == ST_R0) || (state_d == ST_R1)) && (drn_d == 2'd0);
        inv_d    = (state_d == ST_W1) || (state_d == ST_R1);
        addr_a_d = busy_d ? ADDR_WIDTH'({k_d, 1'b0}) : '0;
        addr_b_d = busy_d ? ADDR_WIDTH'({k_d, 1'b1}) : '0;
    end

    bram_bist_pattern #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_pat_a (
        .addr(addr_a_d), .mode(mode_d), .invert(inv_d), .pattern(pat_a)
    );
    bram_bist_pattern #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_pat_b (
        .addr(addr_b_d), .mode(mode_d), .invert(inv_d), .pattern(pat_b)
    );

    always_comb begin
        data_a_d = we_d ? pat_a : '0;
        data_b_d = we_d ? pat_b : '0;
        exp_a_d  = rd_d ? pat_a : '0;
        exp_b_d  = rd_d ? pat_b : '0;

        pv_a_d[0]  = rd_q;
        pv_b_d[0]  = rd_q;
        pe_a_d[0]  = exp_a_q;
        pe_b_d[0]  = exp_b_q;
        pad_a_d[0] = addr_a_q;
        pad_b_d[0] = addr_b_q;
        for (int i = 1; i < L; i++) begin
            pv_a_d[i]  = pv_a_q[i-1];
            pv_b_d[i]  = pv_b_q[i-1];
            pe_a_d[i]  = pe_a_q[i-1];
            pe_b_d[i]  = pe_b_q[i-1];
            pad_a_d[i] = pad_a_q[i-1];
            pad_b_d[i] = pad_b_q[i-1];
        end

        mis_a   = pv_a_q[L-1] && (ram.q_a != pe_a_q[L-1]);
        mis_b   = pv_b_q[L-1] && (ram.q_b != pe_b_q[L-1]);
        err_sum = {1'b0, err_q} + (ERR_WIDTH+1)'(mis_a) + (ERR_WIDTH+1)'(mis_b);
        err_d   = err_sum[ERR_WIDTH] ? '1 : err_sum[ERR_WIDTH-1:0];

        // A zero count means nothing has failed yet, since the counter saturates instead of wrapping.
        eaddr_d = eaddr_q;
        if (err_q == '0) begin
            if (mis_a)      eaddr_d = pad_a_q[L-1];
            else if (mis_b) eaddr_d = pad_b_q[L-1];
        end
        if (go) begin
            err_d   = '0;
            eaddr_d = '0;
        end

        done_d = (state_d == ST_DONE);
        pass_d = done_d && (err_d == '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            k_q      <= '0;
            drn_q    <= '0;
            mode_q   <= '0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            data_a_q <= '0;
            data_b_q <= '0;
            exp_a_q  <= '0;
            exp_b_q  <= '0;
            we_q     <= 1'b0;
            rd_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            err_q    <= '0;
            eaddr_q  <= '0;
            pv_a_q   <= '0;
            pv_b_q   <= '0;
            pe_a_q   <= '0;
            pe_b_q   <= '0;
            pad_a_q  <= '0;
            pad_b_q  <= '0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            drn_q    <= drn_d;
            mode_q   <= mode_d;
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
            data_a_q <= data_a_d;
            data_b_q <= data_b_d;
            exp_a_q  <= exp_a_d;
            exp_b_q  <= exp_b_d;
            we_q     <= we_d;
            rd_q     <= rd_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            err_q    <= err_d;
            eaddr_q  <= eaddr_d;
            pv_a_q   <= pv_a_d;
            pv_b_q   <= pv_b_d;
            pe_a_q   <= pe_a_d;
            pe_b_q   <= pe_b_d;
            pad_a_q  <= pad_a_d;
            pad_b_q  <= pad_b_d;
        end
    end

    assign ram.addr_a = addr_a_q;
    assign ram.addr_b = addr_b_q;
    assign ram.data_a = data_a_q;
    assign ram.data_b = data_b_q;
    assign ram.we_a   = we_q;
    assign ram.we_b   = we_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign err_addr   = eaddr_q;
endmodule

// File: tb/tb_bram_bist.sv
// tb/tb_bram_bist.sv - directed bench for bram_bist against dual-port RAM models with stuck-at-0 faults
module tb_bram_bist;
    localparam int DW = 16;
    localparam int AW = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic       start_v [3];
    logic [1:0] mode_v  [3];

    logic          busy0, done0, pass0, busy1, done1, pass1, busy2, done2, pass2;
    logic [7:0]    err0, err1;
    logic [1:0]    err2;
    logic [AW-1:0] eaddr0, eaddr1, eaddr2;

    bram_bist_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) r0 ();
    bram_bist_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) r1 ();
    bram_bist_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) r2 ();

    bram_bist #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(1), .ERR_WIDTH(8)) u0 (
        .clk(clk), .reset(reset), .start(start_v[0]), .mode(mode_v[0]), .ram(r0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0), .err_addr(eaddr0));
    bram_bist #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(3), .ERR_WIDTH(8)) u1 (
        .clk(clk), .reset(reset), .start(start_v[1]), .mode(mode_v[1]), .ram(r1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .err_addr(eaddr1));
    bram_bist #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(1), .ERR_WIDTH(2)) u2 (
        .clk(clk), .reset(reset), .start(start_v[2]), .mode(mode_v[2]), .ram(r2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2), .err_addr(eaddr2));

    logic [DW-1:0] mem [3][16];
    logic [DW-1:0] sa0 [3][16];
    logic [DW-1:0] pa  [3][3];
    logic [DW-1:0] pb  [3][3];

    function automatic logic [DW-1:0] rd(input int i, input logic [AW-1:0] a);
        return mem[i][a] & ~sa0[i][a];
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            pa[i][2] <= pa[i][1];
            pa[i][1] <= pa[i][0];
            pb[i][2] <= pb[i][1];
            pb[i][1] <= pb[i][0];
        end
        pa[0][0] <= rd(0, r0.addr_a);
        pb[0][0] <= rd(0, r0.addr_b);
        pa[1][0] <= rd(1, r1.addr_a);
        pb[1][0] <= rd(1, r1.addr_b);
        pa[2][0] <= rd(2, r2.addr_a);
        pb[2][0] <= rd(2, r2.addr_b);
        if (r0.we_a) mem[0][r0.addr_a] <= r0.data_a;
        if (r0.we_b) mem[0][r0.addr_b] <= r0.data_b;
        if (r1.we_a) mem[1][r1.addr_a] <= r1.data_a;
        if (r1.we_b) mem[1][r1.addr_b] <= r1.data_b;
        if (r2.we_a) mem[2][r2.addr_a] <= r2.data_a;
        if (r2.we_b) mem[2][r2.addr_b] <= r2.data_b;
    end

    assign r0.q_a = pa[0][0];
    assign r0.q_b = pb[0][0];
    assign r1.q_a = pa[1][2];
    assign r1.q_b = pb[1][2];
    assign r2.q_a = pa[2][0];
    assign r2.q_b = pb[2][0];

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // sel: 0 busy, 1 done, 2 pass, 3 err_count, 4 err_addr
    function automatic logic [31:0] obs(input int i, input int sel);
        logic [31:0] v;
        v = '0;
        case (i)
            0: case (sel) 0: v = 32'(busy0); 1: v = 32'(done0); 2: v = 32'(pass0);
                          3: v = 32'(err0);  default: v = 32'(eaddr0); endcase
            1: case (sel) 0: v = 32'(busy1); 1: v = 32'(done1); 2: v = 32'(pass1);
                          3: v = 32'(err1);  default: v = 32'(eaddr1); endcase
            default: case (sel) 0: v = 32'(busy2); 1: v = 32'(done2); 2: v = 32'(pass2);
                          3: v = 32'(err2);  default: v = 32'(eaddr2); endcase
        endcase
        return v;
    endfunction

    task automatic run(input int i, input logic [1:0] m, input int extra_at,
                       output int cyc, output logic [31:0] err_mid);
        @(posedge clk); #1;
        start_v[i] = 1'b1;
        mode_v[i]  = m;
        @(posedge clk); #1;
        start_v[i] = 1'b0;
        cyc     = 0;
        err_mid = '0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (obs(i, 0) != 0) cyc++;
            if (t == 19) err_mid = obs(i, 3);
            start_v[i] = (t == extra_at);
            if (t == extra_at) mode_v[i] = 2'd2;
            if (obs(i, 1) != 0) break;
        end
        start_v[i] = 1'b0;
        chk("run_done", obs(i, 1), 32'd1);
    endtask

    task automatic chk_zero(input string pfx);
        chk({pfx, "_busy"},   obs(0, 0), 32'd0);
        chk({pfx, "_done"},   obs(0, 1), 32'd0);
        chk({pfx, "_pass"},   obs(0, 2), 32'd0);
        chk({pfx, "_err"},    obs(0, 3), 32'd0);
        chk({pfx, "_eaddr"},  obs(0, 4), 32'd0);
        chk({pfx, "_we"},     32'({r0.we_a, r0.we_b}), 32'd0);
        chk({pfx, "_addr"},   32'({r0.addr_a, r0.addr_b}), 32'd0);
        chk({pfx, "_data"},   {r0.data_a, r0.data_b}, 32'd0);
    endtask

    int          cyc;
    logic [31:0] mid;

    initial begin
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start_v[i] = 1'b0;
            mode_v[i]  = 2'd0;
            for (int a = 0; a < 16; a++) sa0[i][a] = '0;
        end
        repeat (3) @(negedge clk);
        chk_zero("rst");
        reset = 1'b1;

        // Fault-free, address pattern
        run(0, 2'd0, -1, cyc, mid);
        chk("t1_busy_cycles", 32'(cyc), 32'd34);
        chk("t1_pass", obs(0, 2), 32'd1);
        chk("t1_err", obs(0, 3), 32'd0);
        chk("t1_mem5", 32'(mem[0][5]), 32'h0000FFFA);
        chk("t1_mem10", 32'(mem[0][10]), 32'h0000FFF5);
        repeat (3) @(negedge clk);
        chk("t1_done_held", obs(0, 1), 32'd1);
        chk("t1_busy_low", obs(0, 0), 32'd0);

        // Bit 3 of address 6 stuck at 0, all-ones: only R0 sees it
        sa0[0][6] = 16'h0008;
        run(0, 2'd2, -1, cyc, mid);
        chk("t2_busy_cycles", 32'(cyc), 32'd34);
        chk("t2_err", obs(0, 3), 32'd1);
        chk("t2_eaddr", obs(0, 4), 32'd6);
        chk("t2_pass", obs(0, 2), 32'd0);
        sa0[0][6] = '0;

        // Same-cycle faults on both ports, checkerboard
        sa0[0][4] = 16'h0003;
        sa0[0][5] = 16'h0003;
        run(0, 2'd1, -1, cyc, mid);
        chk("t3_err_after_r0", mid, 32'd2);
        chk("t3_err", obs(0, 3), 32'd4);
        chk("t3_eaddr", obs(0, 4), 32'd4);
        chk("t3_pass", obs(0, 2), 32'd0);
        sa0[0][4] = '0;
        sa0[0][5] = '0;

        // Read latency 3, XOR pattern
        run(1, 2'd3, -1, cyc, mid);
        chk("t4_busy_cycles", 32'(cyc), 32'd38);
        chk("t4_pass", obs(1, 2), 32'd1);
        chk("t4_err", obs(1, 3), 32'd0);
        chk("t4_mem5", 32'(mem[1][5]), 32'h00005A5F);

        // Every word faulty, 2-bit counter saturates
        for (int a = 0; a < 16; a++) sa0[2][a] = 16'h0001;
        run(2, 2'd2, -1, cyc, mid);
        chk("t5_err_sat", obs(2, 3), 32'd3);
        chk("t5_eaddr", obs(2, 4), 32'd0);
        chk("t5_pass", obs(2, 2), 32'd0);

        // Reset mid-R0, then a run with a stray start while busy
        @(posedge clk); #1;
        start_v[0] = 1'b1;
        mode_v[0]  = 2'd0;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        repeat (12) @(negedge clk);
        chk("t6_in_run", obs(0, 0), 32'd1);
        reset = 1'b0;
        #1;
        chk_zero("t6_rst");
        @(negedge clk);
        reset = 1'b1;
        run(0, 2'd0, 5, cyc, mid);
        chk("t6_busy_cycles", 32'(cyc), 32'd34);
        chk("t6_pass", obs(0, 2), 32'd1);
        chk("t6_err", obs(0, 3), 32'd0);
        chk("t6_mem5", 32'(mem[0][5]), 32'h0000FFFA);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
